// File: rtl/scan_pkg.sv
// ============================================================================
// Module   : scan_pkg
// Brief    : Shared scan-master state encodings and sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    // Bit counter must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_controller_if.sv
// ============================================================================
// Module   : scan_controller_if
// Brief    : Host request/response handshake bundle for the scan controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface scan_controller_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CHAIN_LEN-1:0] req_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;

    modport master (
        output req_valid,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

`default_nettype wire

// File: rtl/scan_controller.sv
// ============================================================================
// Module   : scan_controller
// Brief    : Loads a word into a serial scan chain while capturing its old
//            contents through one shared shift register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scan_controller
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    scan_controller_if.slave  bus,
    output logic              scan_enable,
    output logic              scan_in,
    input  wire logic         scan_out
);

    localparam int             CW     = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0]  C_LAST = CW'(CHAIN_LEN - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [CHAIN_LEN-1:0] r_shreg;
    logic [CHAIN_LEN-1:0] w_shreg_nxt;
    logic [CHAIN_LEN-1:0] w_shifted;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;

    generate
        if (CHAIN_LEN == 1) begin : g_len_one
            assign w_shifted = scan_out;
        end else begin : g_len_many
            assign w_shifted = {r_shreg[CHAIN_LEN-2:0], scan_out};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_shreg_nxt = bus.req_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Chain and register shift together, so after CHAIN_LEN edges
                // they have swapped contents.
                w_shreg_nxt = w_shifted;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (r_cnt == C_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == DONE);
    assign bus.resp_data  = r_shreg;
    assign scan_enable    = (r_state == SHIFT);
    assign scan_in        = r_shreg[CHAIN_LEN-1];

endmodule

`default_nettype wire

// File: tb/tb_scan_controller.sv
// ============================================================================
// Module   : tb_scan_controller
// Brief    : Directed vector bench for scan_controller with behavioural chains.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scan_controller;
    import scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    scan_controller_if #(.CHAIN_LEN(8)) bus8 ();
    scan_controller_if #(.CHAIN_LEN(1)) bus1 ();

    logic       se8, si8, so8;
    logic       se1, si1, so1;
    logic [7:0] chain8;
    logic       chain1;
    logic       pre8_en, pre1_en;
    logic [7:0] pre8_val;
    logic       pre1_val;

    scan_controller #(.CHAIN_LEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave),
        .scan_enable(se8), .scan_in(si8), .scan_out(so8)
    );

    scan_controller #(.CHAIN_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .scan_enable(se1), .scan_in(si1), .scan_out(so1)
    );

    // Behavioural scan chains: shift toward the MSB, which feeds scan_out.
    always @(posedge clk) begin
        if (pre8_en)  chain8 <= pre8_val;
        else if (se8) chain8 <= {chain8[6:0], si8};
        if (pre1_en)  chain1 <= pre1_val;
        else if (se1) chain1 <= si1;
    end
    assign so8 = chain8[7];
    assign so1 = chain1;

    typedef struct {
        logic [7:0] req;
        bit         pre;
        logic [7:0] pre_val;
        logic [7:0] exp_resp;
        logic [7:0] exp_chain;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload8(input logic [7:0] v);
        pre8_en = 1'b1; pre8_val = v;
        @(negedge clk);
        pre8_en = 1'b0;
    endtask

    // Called right after the acceptance edge; completes and retires the response.
    task automatic finish8(input string tag, input logic [7:0] exp_resp, input logic [7:0] exp_chain);
        int k = 0;
        int se_cnt = 0;
        bit got = 0;
        while (k < 30 && !got) begin
            @(negedge clk);
            bus8.req_valid = 1'b0;
            k++;
            if (se8) se_cnt++;
            if (bus8.resp_valid) got = 1;
        end
        chk({tag, "_latency"}, k, 9);
        chk({tag, "_se_cycles"}, se_cnt, 8);
        chk({tag, "_resp_data"}, bus8.resp_data, exp_resp);
        chk({tag, "_chain"}, chain8, exp_chain);
        chk({tag, "_ready_in_done"}, bus8.req_ready, 1'b0);
        bus8.resp_ready = 1'b1;
        @(negedge clk);
        bus8.resp_ready = 1'b0;
        chk({tag, "_resp_retired"}, bus8.resp_valid, 1'b0);
        chk({tag, "_ready_idle"}, bus8.req_ready, 1'b1);
    endtask

    task automatic run8(input string tag, input logic [7:0] req, input logic [7:0] exp_resp,
                        input logic [7:0] exp_chain);
        bus8.req_valid = 1'b1;
        bus8.req_data  = req;
        chk({tag, "_ready_before"}, bus8.req_ready, 1'b1);
        @(posedge clk);
        finish8(tag, exp_resp, exp_chain);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int acc, nresp, k, se_cnt;
        int acc_cyc[2];
        int resp_cyc[2];
        logic [7:0] resp_val[2];
        bit bad;

        vt[0] = '{req: 8'hA5, pre: 1'b1, pre_val: 8'h3C, exp_resp: 8'h3C, exp_chain: 8'hA5};
        vt[1] = '{req: 8'h5A, pre: 1'b0, pre_val: 8'h00, exp_resp: 8'hA5, exp_chain: 8'h5A};
        vt[2] = '{req: 8'h00, pre: 1'b0, pre_val: 8'h00, exp_resp: 8'h5A, exp_chain: 8'h00};
        vt[3] = '{req: 8'hC3, pre: 1'b1, pre_val: 8'h81, exp_resp: 8'h81, exp_chain: 8'hC3};

        rst_n = 1'b0;
        bus8.req_valid = 1'b0; bus8.req_data = '0; bus8.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_data = '0; bus1.resp_ready = 1'b0;
        pre8_en = 1'b0; pre8_val = '0; pre1_en = 1'b0; pre1_val = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", bus8.req_ready, 1'b1);
        chk("rst_resp_valid", bus8.resp_valid, 1'b0);
        chk("rst_resp_data", bus8.resp_data, 8'h00);
        chk("rst_scan_enable", se8, 1'b0);
        chk("rst_scan_in", si8, 1'b0);
        chk("rst1_req_ready", bus1.req_ready, 1'b1);
        chk("rst1_scan_enable", se1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            if (vt[i].pre) preload8(vt[i].pre_val);
            run8($sformatf("vec%0d", i), vt[i].req, vt[i].exp_resp, vt[i].exp_chain);
        end

        // Back-to-back requests with both handshakes held high.
        preload8(8'h3C);
        bus8.req_valid = 1'b1; bus8.req_data = 8'h01; bus8.resp_ready = 1'b1;
        acc = 0; nresp = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; resp_cyc[0] = 0; resp_cyc[1] = 0;
        resp_val[0] = '0; resp_val[1] = '0;
        for (int c = 0; c < 40 && nresp < 2; c++) begin
            if (acc == 1) bus8.req_data = 8'hFF;
            if (acc >= 2) bus8.req_valid = 1'b0;
            if (bus8.req_valid && bus8.req_ready && acc < 2) begin
                acc_cyc[acc] = c; acc++;
            end
            if (bus8.resp_valid) begin
                resp_cyc[nresp] = c; resp_val[nresp] = bus8.resp_data; nresp++;
            end
            @(negedge clk);
        end
        bus8.resp_ready = 1'b0;
        bus8.req_valid  = 1'b0;
        chk("b2b_resp_count", nresp, 2);
        chk("b2b_resp0", resp_val[0], 8'h3C);
        chk("b2b_resp1", resp_val[1], 8'h01);
        chk("b2b_resp_gap", resp_cyc[1] - resp_cyc[0], 10);
        chk("b2b_accept_gap", acc_cyc[1] - acc_cyc[0], 10);
        chk("b2b_chain", chain8, 8'hFF);

        // Response stalled in DONE while another request is offered.
        bus8.req_valid = 1'b1; bus8.req_data = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus8.req_valid = 1'b0;
        k = 0;
        while (k < 30 && !bus8.resp_valid) begin
            @(negedge clk);
            k++;
        end
        chk("stall_reached_done", bus8.resp_valid, 1'b1);
        bus8.req_valid = 1'b1; bus8.req_data = 8'h11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_resp_valid", bus8.resp_valid, 1'b1);
            chk("stall_resp_data", bus8.resp_data, 8'hFF);
            chk("stall_req_ready", bus8.req_ready, 1'b0);
            chk("stall_scan_enable", se8, 1'b0);
        end
        bus8.req_valid = 1'b0; bus8.resp_ready = 1'b1;
        @(negedge clk);
        bus8.resp_ready = 1'b0;
        chk("stall_release_ready", bus8.req_ready, 1'b1);
        chk("stall_chain", chain8, 8'h77);
        @(negedge clk);
        chk("stall_no_stray_accept", se8, 1'b0);

        // Single-bit chain.
        pre1_en = 1'b1; pre1_val = 1'b1;
        @(negedge clk);
        pre1_en = 1'b0;
        bus1.req_valid = 1'b1; bus1.req_data = 1'b0;
        k = 0; se_cnt = 0;
        while (k < 10 && !bus1.resp_valid) begin
            @(negedge clk);
            bus1.req_valid = 1'b0;
            k++;
            if (se1) se_cnt++;
        end
        chk("len1_latency", k, 2);
        chk("len1_se_cycles", se_cnt, 1);
        chk("len1_resp_data", bus1.resp_data, 1'b1);
        chk("len1_chain", chain1, 1'b0);
        bus1.resp_ready = 1'b1;
        @(negedge clk);
        bus1.resp_ready = 1'b0;
        chk("len1_ready_idle", bus1.req_ready, 1'b1);

        // Reset pulse after the third shift edge.
        bus8.req_valid = 1'b1; bus8.req_data = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        bus8.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_scan_enable", se8, 1'b0);
        chk("rstmid_resp_valid", bus8.resp_valid, 1'b0);
        chk("rstmid_req_ready", bus8.req_ready, 1'b1);
        chk("rstmid_resp_data", bus8.resp_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus8.resp_valid || se8) bad = 1;
        end
        chk("rstmid_no_response", bad, 1'b0);
        chk("rstmid_chain_partial", chain8, 8'hBE);
        run8("after_rst", 8'h5A, 8'hBE, 8'h5A);

        // Request raised together with reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus8.req_valid = 1'b1; bus8.req_data = 8'h3C;
        @(posedge clk);
        finish8("rst_release", 8'h5A, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scan_controller.md
SCAN_CONTROLLER -- requirements
Module: scan_controller

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, giving the scan-chain length in bits; legal range is 1 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: the host offers a shift request.
REQ-005 SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-006 SHALL have port req_data, input, CHAIN_LEN bits: the word to load into the chain.
REQ-007 SHALL have port resp_valid, output, 1 bit: resp_data holds the captured word.
REQ-008 SHALL have port resp_ready, input, 1 bit: the host accepts the response.
REQ-009 SHALL have port resp_data, output, CHAIN_LEN bits: the chain contents captured during the shift.
REQ-010 SHALL have port scan_enable, output, 1 bit: the chain's shift enable.
REQ-011 SHALL have port scan_in, output, 1 bit: the serial data driven into the chain's LSB end.
REQ-012 SHALL have port scan_out, input, 1 bit: the chain's MSB, sampled by the controller.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE, and SHALL assert req_ready only in IDLE.
REQ-014 SHALL accept a request on an edge where req_valid and req_ready are both high, loading req_data into the shift register S, clearing the bit counter and entering SHIFT.
REQ-015 SHALL drive scan_enable high exactly while in SHIFT, with no combinational path from req_valid.
REQ-016 SHALL drive scan_in from S[CHAIN_LEN-1] at all times, so the chain receives req_data MSB-first.
REQ-017 SHALL, on each edge in SHIFT, update S to {S[CHAIN_LEN-2:0], scan_out}; for CHAIN_LEN=1, S takes scan_out.
REQ-018 SHALL, on each edge in SHIFT, increment the counter, which is $clog2(CHAIN_LEN+1) bits wide, and SHALL move to DONE on the edge where the counter reaches CHAIN_LEN-1.
REQ-019 SHALL complete exactly CHAIN_LEN scan_enable cycles per request, so resp_valid rises CHAIN_LEN+1 edges after acceptance.
REQ-020 SHALL, on DONE entry, hold the chain's prior contents in S (resp_data = S), while the chain holds req_data.
REQ-021 SHALL hold resp_valid high and resp_data stable in DONE until resp_ready is high, then return to IDLE on that edge.
REQ-022 SHALL ignore req_valid outside IDLE; a request arriving in DONE is taken no earlier than the cycle after the return to IDLE.
REQ-023 SHALL ignore resp_ready outside DONE.
REQ-024 SHALL provide back-to-back throughput of one request per CHAIN_LEN+2 cycles when req_valid and resp_ready are held high.

Reset
REQ-025 SHALL, with rst_n low, force IDLE, S=0, counter=0, scan_enable=0, scan_in=0, resp_valid=0, resp_data=0 and req_ready=1, asynchronously.
REQ-026 SHALL, on reset during SHIFT, drop scan_enable immediately, abandon the transfer with no response, and leave the chain partially shifted; the host re-issues the request.
REQ-027 SHALL resume request acceptance on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) in shared package scan_pkg for reuse by the bench and other scan masters.
REQ-029 SHALL be a single module with no sub-module; the single register S serves both as transmit and capture register.

Verification
REQ-030 SHALL be covered by: CHAIN_LEN=8, chain preloaded 0x3C, request 0xA5 -> exactly 8 scan_enable cycles, resp_valid on the 9th edge, resp_data=0x3C, chain=0xA5.
REQ-031 SHALL be covered by: two requests 0x01 then 0xFF with resp_ready held high -> resp_data 0x3C then 0x01, 10 cycles apart.
REQ-032 SHALL be covered by: resp_ready held low for 5 cycles in DONE -> resp_valid held, resp_data stable, req_ready low, and a concurrent req_valid not accepted.
REQ-033 SHALL be covered by: rst_n pulsed low after the 3rd shift cycle -> scan_enable and resp_valid drop at once, no response, next request 0x5A works normally.
REQ-034 SHALL be covered by: CHAIN_LEN=1, chain holds 1, request 0 -> one scan_enable cycle, resp_data=1, chain=0.
REQ-035 SHALL be covered by: a request whose req_valid is raised in the same cycle as rst_n deasserts -> accepted on the first rising edge after deassertion.
